datamem_master: RTL and testbench

Bus-side initiator for the 8-bit data memory: accepts single or burst read/write requests from the core and sequences the memory's control strobes (address load, data write, data read) on the shared 8-bit bus. Each beat is an address phase followed by a data phase, since the memory has no auto-increment. Sits between the control unit/DMA logic and the data memory on the shared bus.

---
 rtl/datamem_master_if.sv | 32 +++
 rtl/datamem_master.sv | 120 ++++++++++++
 tb/tb_datamem_master.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/datamem_master_if.sv
// Request, write/read data and shared-bus signals between datamem_master and its core/memory side.
interface datamem_master_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic [7:0] req_addr;
    logic [3:0] req_len;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       done;
    logic       err;
    logic [7:0] bus_in;
    logic [7:0] bus_out;
    logic       bus_drive;
    logic       c_memaddr;
    logic       c_datawrite;
    logic       c_dataread;

    modport master (
        input  req_valid, req_write, req_addr, req_len, wr_data, bus_in,
        output req_ready, wr_ready, rd_data, rd_valid, done, err,
               bus_out, bus_drive, c_memaddr, c_datawrite, c_dataread
    );

    modport slave (
        output req_valid, req_write, req_addr, req_len, wr_data, bus_in,
        input  req_ready, wr_ready, rd_data, rd_valid, done, err,
               bus_out, bus_drive, c_memaddr, c_datawrite, c_dataread
    );
endinterface

// File: rtl/datamem_master.sv
// Burst initiator for the 8-bit data memory: address phase then data phase per beat.
// Define DATAMEM_MASTER_WRAP_EN to let bursts wrap 0xFF->0x00 instead of truncating with err.
module datamem_master (
    input  logic               clk,
    input  logic               reset,
    datamem_master_if.master   dm
);
`ifdef DATAMEM_MASTER_WRAP_EN
    localparam bit WrapEn = 1'b1;
`else
    localparam bit WrapEn = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

    state_t     state;
    logic       write_q;
    logic [7:0] cur_addr;
    logic [3:0] beats_left;
    logic [7:0] addr_out;
    logic [7:0] rd_data_q;
    logic       req_ready_q, wr_ready_q, rd_valid_q, done_q, err_q;
    logic       drive_q, memaddr_q, datawrite_q, dataread_q;
    logic       at_top;

    assign at_top = !WrapEn && (cur_addr == 8'hFF);

    // Outputs are registered for the state being entered; only the write-data mux is combinational
    // because wr_data is consumed in the same cycle it is presented.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            write_q     <= 1'b0;
            cur_addr    <= '0;
            beats_left  <= '0;
            addr_out    <= '0;
            rd_data_q   <= '0;
            req_ready_q <= 1'b1;
            wr_ready_q  <= 1'b0;
            rd_valid_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            drive_q     <= 1'b0;
            memaddr_q   <= 1'b0;
            datawrite_q <= 1'b0;
            dataread_q  <= 1'b0;
        end else begin
            req_ready_q <= 1'b0;
            wr_ready_q  <= 1'b0;
            rd_valid_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            drive_q     <= 1'b0;
            memaddr_q   <= 1'b0;
            datawrite_q <= 1'b0;
            dataread_q  <= 1'b0;
            addr_out    <= '0;
            case (state)
                IDLE: begin
                    if (dm.req_valid) begin
                        write_q    <= dm.req_write;
                        cur_addr   <= dm.req_addr;
                        beats_left <= dm.req_len;
                        state      <= ADDR;
                        drive_q    <= 1'b1;
                        memaddr_q  <= 1'b1;
                        addr_out   <= dm.req_addr;
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                ADDR: begin
                    state <= DATA;
                    if (write_q) begin
                        drive_q     <= 1'b1;
                        datawrite_q <= 1'b1;
                        wr_ready_q  <= 1'b1;
                    end else begin
                        dataread_q <= 1'b1;
                    end
                end
                DATA: begin
                    if (!write_q) begin
                        rd_data_q  <= dm.bus_in;
                        rd_valid_q <= 1'b1;
                    end
                    if (beats_left == 4'd0 || at_top) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                        err_q  <= (beats_left != 4'd0);
                    end else begin
                        beats_left <= beats_left - 4'd1;
                        cur_addr   <= cur_addr + 8'd1;
                        state      <= ADDR;
                        drive_q    <= 1'b1;
                        memaddr_q  <= 1'b1;
                        addr_out   <= cur_addr + 8'd1;
                    end
                end
                DONE: begin
                    state       <= IDLE;
                    req_ready_q <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign dm.req_ready   = req_ready_q;
    assign dm.wr_ready    = wr_ready_q;
    assign dm.rd_data     = rd_data_q;
    assign dm.rd_valid    = rd_valid_q;
    assign dm.done        = done_q;
    assign dm.err         = err_q;
    assign dm.bus_drive   = drive_q;
    assign dm.c_memaddr   = memaddr_q;
    assign dm.c_datawrite = datawrite_q;
    assign dm.c_dataread  = dataread_q;
    assign dm.bus_out     = datawrite_q ? dm.wr_data : addr_out;
endmodule

// File: tb/tb_datamem_master.sv
// Bench for datamem_master: table of directed bursts, random bursts against a beat-level model,
// plus mid-burst reset; a simple memory model sits on the bus.
module tb_datamem_master;
    logic clk = 1'b0;
    logic reset;
    datamem_master_if dmi ();

    datamem_master dut (.clk(clk), .reset(reset), .dm(dmi));

    always #5 clk = ~clk;

    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];
    logic [7:0] mem_addr;
    logic [7:0] wdata [16];
    int n_cmp = 0;
    int n_fail = 0;

    always @(posedge clk) begin
        if (dmi.c_memaddr) mem_addr <= dmi.bus_out;
        if (dmi.c_datawrite) mem[mem_addr] <= dmi.bus_out;
    end
    assign dmi.bus_in = mem[mem_addr];

    typedef struct {
        bit         write;
        logic [7:0] addr;
        logic [3:0] len;
        logic [7:0] data0;
        bit         hold;
        int         exp_done;
        bit         exp_err;
    } vec_t;

    function automatic logic [8:0] flags();
        return {dmi.req_ready, dmi.c_memaddr, dmi.c_datawrite, dmi.c_dataread,
                dmi.wr_ready, dmi.bus_drive, dmi.rd_valid, dmi.done, dmi.err};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Beat-level model: cycle c after accept belongs to beat (c-1)/2, odd = address phase.
    task automatic run_burst(input bit w, input logic [7:0] a, input logic [3:0] l, input bit hold,
                             output int done_at, output bit err_seen);
        int n, ne, b;
        bit trunc;
        logic [8:0] exp;
        logic [7:0] ab;
        n = int'(l) + 1;
        ne = n;
`ifndef DATAMEM_MASTER_WRAP_EN
        if (int'(a) + n > 256) ne = 256 - int'(a);
`endif
        trunc = (ne < n);
        @(negedge clk);
        #1;
        check("idle_flags", flags(), 9'b100000000);
        dmi.req_valid = 1'b1;
        dmi.req_write = w;
        dmi.req_addr  = a;
        dmi.req_len   = l;
        dmi.wr_data   = wdata[0];
        done_at  = 0;
        err_seen = 1'b0;
        for (int c = 1; c <= 2 * ne + 1; c++) begin
            @(negedge clk);
            if (!hold) dmi.req_valid = 1'b0;
            b = (c - 1) / 2;
            if (b > 15) b = 15;
            dmi.wr_data = wdata[b];
            #1;
            ab  = a + 8'(b);
            exp = '0;
            if (c <= 2 * ne) begin
                if (c % 2 == 1) exp = 9'b010001000;
                else if (w)     exp = 9'b001011000;
                else            exp = 9'b000100000;
            end
            if (!w && c >= 3 && c % 2 == 1) exp[2] = 1'b1;
            if (c == 2 * ne + 1) begin
                exp[1] = 1'b1;
                exp[0] = trunc;
            end
            check("cycle_flags", flags(), exp);
            if (exp[3]) check("bus_out", dmi.bus_out, (c % 2 == 1) ? ab : wdata[b]);
            if (exp[2]) check("rd_data", dmi.rd_data, ref_mem[8'(a + 8'((c - 3) / 2))]);
            if (dmi.done && done_at == 0) begin
                done_at  = c;
                err_seen = dmi.err;
            end
            if (w && c % 2 == 0 && c <= 2 * ne) ref_mem[ab] = wdata[b];
        end
    endtask

    initial begin
        vec_t vecs[6];
        int   done_at, diffs;
        bit   err_seen, w, hold;
        logic [7:0] a;
        logic [3:0] l;

        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'(i) ^ 8'h5A;
            ref_mem[i] = 8'(i) ^ 8'h5A;
        end
        mem_addr      = '0;
        reset         = 1'b1;
        dmi.req_valid = 1'b0;
        dmi.req_write = 1'b0;
        dmi.req_addr  = '0;
        dmi.req_len   = '0;
        dmi.wr_data   = '0;
        #12;
        check("reset_flags", flags(), 9'b100000000);
        check("reset_bus_out", dmi.bus_out, 8'h00);
        check("reset_rd_data", dmi.rd_data, 8'h00);
        @(negedge clk);
        reset = 1'b0;

        vecs[0] = '{1'b1, 8'h10, 4'd0, 8'hA5, 1'b0, 3, 1'b0};
        vecs[1] = '{1'b0, 8'h10, 4'd0, 8'h00, 1'b0, 3, 1'b0};
        vecs[2] = '{1'b1, 8'h20, 4'd3, 8'h01, 1'b1, 9, 1'b0};
        vecs[3] = '{1'b0, 8'h20, 4'd3, 8'h00, 1'b1, 9, 1'b0};
`ifdef DATAMEM_MASTER_WRAP_EN
        vecs[4] = '{1'b1, 8'hFE, 4'd2, 8'h77, 1'b0, 7, 1'b0};
        vecs[5] = '{1'b0, 8'hFE, 4'd2, 8'h00, 1'b0, 7, 1'b0};
`else
        vecs[4] = '{1'b1, 8'hFE, 4'd2, 8'h77, 1'b0, 5, 1'b1};
        vecs[5] = '{1'b0, 8'hFE, 4'd2, 8'h00, 1'b0, 5, 1'b1};
`endif
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < 16; k++) wdata[k] = vecs[i].data0 + 8'(k);
            run_burst(vecs[i].write, vecs[i].addr, vecs[i].len, vecs[i].hold, done_at, err_seen);
            check("vec_done_cycle", 32'(done_at), 32'(vecs[i].exp_done));
            check("vec_err", 32'(err_seen), 32'(vecs[i].exp_err));
        end
        check("mem_10", mem[8'h10], 8'hA5);
        check("mem_23", mem[8'h23], 8'h04);
        check("mem_ff", mem[8'hFF], 8'h78);
`ifdef DATAMEM_MASTER_WRAP_EN
        check("mem_00", mem[8'h00], 8'h79);
`else
        check("mem_00", mem[8'h00], 8'h5A);
`endif

        for (int i = 0; i < 24; i++) begin
            w    = 1'($urandom_range(0, 1));
            hold = 1'($urandom_range(0, 1));
            a    = 8'($urandom_range(0, 255));
            if (i % 4 == 0) a = 8'hF0 + 8'($urandom_range(0, 15));
            l    = 4'($urandom_range(0, 15));
            for (int k = 0; k < 16; k++) wdata[k] = 8'($urandom);
            run_burst(w, a, l, hold, done_at, err_seen);
        end

        // Reset during the data phase of beat 2 of a 4-beat write.
        for (int k = 0; k < 16; k++) wdata[k] = 8'h91 + 8'(k);
        @(negedge clk);
        dmi.req_valid = 1'b0;
        #1;
        check("rst_seq_idle", flags(), 9'b100000000);
        dmi.req_valid = 1'b1;
        dmi.req_write = 1'b1;
        dmi.req_addr  = 8'h40;
        dmi.req_len   = 4'd3;
        dmi.wr_data   = wdata[0];
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            dmi.req_valid = 1'b0;
            dmi.wr_data = wdata[(c - 1) / 2];
        end
        ref_mem[8'h40] = 8'h91;
        @(negedge clk);
        dmi.wr_data = wdata[1];
        #1;
        check("rst_seq_beat2", flags(), 9'b001011000);
        #1;
        reset = 1'b1;
        #1;
        check("rst_async_flags", flags(), 9'b100000000);
        check("rst_async_bus_out", dmi.bus_out, 8'h00);
        check("rst_async_rd_data", dmi.rd_data, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        check("rst_mem_40", mem[8'h40], 8'h91);
        check("rst_mem_41", mem[8'h41], ref_mem[8'h41]);

        for (int k = 0; k < 16; k++) wdata[k] = 8'($urandom);
        run_burst(1'b0, 8'h40, 4'd1, 1'b0, done_at, err_seen);
        check("post_rst_done", 32'(done_at), 32'd5);

        diffs = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) diffs++;
        check("mem_contents_diffs", 32'(diffs), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
